retry_manager: RTL
==================

Name: retry_manager

Overview:
- Retry-buffer management controller for the data link layer transmit path.
- Allocates retry FIFO slots to outgoing TLPs and records each slot's sequence number.
- Frees slots on ACK DLLPs. On a NAK or replay-timer expiry, sequences in-order replay through the per-slot retry_valid/ack/complete handshake of the retry transmitter.
- Tracks REPLAY_NUM and flags rollover for link retrain.

Parameters:
- RETRY_TLP_SIZE, 3: number of retry slots (FIFOs); max 256.
- SEQ_WIDTH, 12: TLP sequence number width.
- REPLAY_TIMEOUT, 1024: replay timer expiry, in clk_i cycles.
- REPLAY_NUM_MAX, 3: replays allowed before rollover.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- tlp_start_i  in  1  first beat of a new TLP accepted into the retry buffer.
- tlp_seq_i  in  SEQ_WIDTH  sequence number of that TLP; sampled with tlp_start_i.
- tlp_end_i  in  1  last beat of the TLP written; commits the slot.
- retry_available_o  out  1  a free slot exists and the block is not replaying.
- retry_index_o  out  8  slot to write; zero-extended wr_ptr.
- ack_valid_i  in  1  ACK DLLP received.
- nak_valid_i  in  1  NAK DLLP received; has priority over ack_valid_i in the same cycle.
- ackd_seq_i  in  SEQ_WIDTH  AckNak_Seq_Num.
- slot_free_o  out  RETRY_TLP_SIZE  one-cycle pulse; that slot's contents are acknowledged and must be purged.
- retry_valid_o  out  RETRY_TLP_SIZE  one-hot replay request.
- retry_ack_i  in  RETRY_TLP_SIZE  transmitter accepted the request.
- retry_complete_i  in  RETRY_TLP_SIZE  transmitter sent the slot's last beat.
- replay_active_o  out  1  replay in progress; blocks new TLP transmission.
- replay_rollover_o  out  1  one-cycle pulse on REPLAY_NUM rollover.

Behaviour:
- Slot table per entry: seq. Ring pointers: wr_ptr and rd_ptr (both wrap at RETRY_TLP_SIZE-1 back to 0), plus count (0..RETRY_TLP_SIZE).
- Reset values: all pointers, count, replay_num and timer = 0; state = IDLE; all outputs 0, except retry_available_o = 1 once out of reset.
- retry_available_o = (count < RETRY_TLP_SIZE) && state == IDLE. Combinational, 0-cycle.
- Allocate:
  - tlp_start_i latches tlp_seq_i into seq[wr_ptr].
  - tlp_end_i: wr_ptr++ and count++.
  - tlp_start_i/tlp_end_i while retry_available_o = 0 are ignored.
  - Start and end in the same cycle form a valid single-beat TLP.
- "Acked" test for oldest slot: count > 0 and ((ackd - seq[rd_ptr]) mod 2^SEQ_WIDTH) < 2^(SEQ_WIDTH-1).
- States:
  - IDLE:
    - ACK/NAK latches ackd_seq and goes to PURGE; NAK also sets nak_pend.
    - Timer expiry with count > 0 goes to REPLAY_REQ with rd_ptr as the replay pointer (rp).
  - PURGE: each cycle, while the oldest slot is acked, pulse slot_free_o[rd_ptr], rd_ptr++, count--. At most one slot per cycle. Then:
    - If nak_pend and count > 0: rp = rd_ptr, go to REPLAY_REQ.
    - Otherwise: clear nak_pend, go to IDLE.
  - REPLAY_REQ:
    - On entry from IDLE or PURGE: replay_num++. If it was REPLAY_NUM_MAX, it becomes 0 and replay_rollover_o pulses; replay still proceeds.
    - Hold retry_valid_o[rp] = 1 until retry_ack_i[rp], then go to REPLAY_WAIT.
  - REPLAY_WAIT: on retry_complete_i[rp], advance rp.
    - If slots remain (rp != wr_ptr), go to REPLAY_REQ without incrementing replay_num.
    - Otherwise go to IDLE, reset the timer and clear nak_pend.
- Allocation during a commit: a tlp_end_i arriving in the same cycle PURGE frees a slot is committed; count nets +1-1.
- replay_active_o = 1 in REPLAY_REQ and REPLAY_WAIT. An ACK/NAK arriving there is latched (latest wins) and processed as PURGE on return to IDLE, before any new allocation.
- Replay timer:
  - Counts while count > 0 and state == IDLE.
  - Resets to 0 when PURGE frees at least one slot, and also resets on replay end.
  - Holds at 0 when count == 0.
  - Expires when it reaches REPLAY_TIMEOUT-1.
- replay_num resets to 0 whenever PURGE frees at least one slot.
- Reset mid-operation: state returns to IDLE and all slots are discarded; no pulses are emitted.

Test Plan:
1. Allocate three TLPs with seq 5, 6, 7 -> retry_index_o 0, 1, 2; after the third, retry_available_o = 0 and count = 3.
2. ACK seq 6 -> slot_free_o pulses 001 then 010 on consecutive cycles; count = 1, retry_available_o = 1, timer = 0.
3. NAK seq 5 with slots seq 5, 6, 7 -> slot 0 freed; retry_valid_o = 010 until ack; after complete, 100; after complete, IDLE; replay_num = 1.
4. No ACK for REPLAY_TIMEOUT cycles with count = 2 -> replay of both slots; four consecutive timeouts with no ACK -> replay_rollover_o pulses on the 4th, replay_num = 0.
5. Seq wrap: slots with seq 4094, 4095, 0; ACK seq 0 -> all three freed in 3 cycles.
6. ACK arriving during replay -> latched, applied after replay; rst_i mid-replay -> retry_valid_o = 0 next cycle, count = 0.

Source files
------------

// File: rtl/retry_manager_if.sv
// Transmit-path retry buffer bus: TLP allocation, ACK/NAK intake,
// slot purge pulses and the per-slot replay handshake.
interface retry_manager_if #(
  parameter int unsigned RETRY_TLP_SIZE = 3,
  parameter int unsigned SEQ_WIDTH      = 12
);
  logic                      tlp_start_i;
  logic [SEQ_WIDTH-1:0]      tlp_seq_i;
  logic                      tlp_end_i;
  logic                      retry_available_o;
  logic [7:0]                retry_index_o;
  logic                      ack_valid_i;
  logic                      nak_valid_i;
  logic [SEQ_WIDTH-1:0]      ackd_seq_i;
  logic [RETRY_TLP_SIZE-1:0] slot_free_o;
  logic [RETRY_TLP_SIZE-1:0] retry_valid_o;
  logic [RETRY_TLP_SIZE-1:0] retry_ack_i;
  logic [RETRY_TLP_SIZE-1:0] retry_complete_i;
  logic                      replay_active_o;
  logic                      replay_rollover_o;

  modport slave (
    input  tlp_start_i, tlp_seq_i, tlp_end_i, ack_valid_i, nak_valid_i, ackd_seq_i,
           retry_ack_i, retry_complete_i,
    output retry_available_o, retry_index_o, slot_free_o, retry_valid_o,
           replay_active_o, replay_rollover_o
  );

  modport master (
    output tlp_start_i, tlp_seq_i, tlp_end_i, ack_valid_i, nak_valid_i, ackd_seq_i,
           retry_ack_i, retry_complete_i,
    input  retry_available_o, retry_index_o, slot_free_o, retry_valid_o,
           replay_active_o, replay_rollover_o
  );
endinterface

// File: rtl/retry_manager.sv
// Data link layer retry buffer controller: slot allocation, ACK/NAK purge,
// in-order replay on NAK or replay-timer expiry, and REPLAY_NUM rollover.
module retry_manager #(
  parameter int unsigned RETRY_TLP_SIZE = 3,
  parameter int unsigned SEQ_WIDTH      = 12,
  parameter int unsigned REPLAY_TIMEOUT = 1024,
  parameter int unsigned REPLAY_NUM_MAX = 3
) (
  input logic            clk_i,
  input logic            rst_i,
  retry_manager_if.slave bus
);

  localparam int unsigned PTR_W = (RETRY_TLP_SIZE > 1) ? $clog2(RETRY_TLP_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(RETRY_TLP_SIZE + 1);
  localparam int unsigned TMR_W = (REPLAY_TIMEOUT > 1) ? $clog2(REPLAY_TIMEOUT) : 1;
  localparam int unsigned RN_W  = (REPLAY_NUM_MAX > 0) ? $clog2(REPLAY_NUM_MAX + 1) : 1;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PURGE       = 2'd1;
  localparam logic [1:0] REPLAY_REQ  = 2'd2;
  localparam logic [1:0] REPLAY_WAIT = 2'd3;

  localparam logic [RETRY_TLP_SIZE-1:0] SLOT_ONE = RETRY_TLP_SIZE'(1);
  localparam logic [TMR_W-1:0]          TMR_LAST = TMR_W'(REPLAY_TIMEOUT - 1);
  localparam logic [RN_W-1:0]           RN_MAX   = RN_W'(REPLAY_NUM_MAX);
  localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(RETRY_TLP_SIZE);

  logic [1:0]           state, state_d;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, rp, rp_d;
  logic [CNT_W-1:0]     count, count_d;
  logic [SEQ_WIDTH-1:0] seq [RETRY_TLP_SIZE];
  logic [SEQ_WIDTH-1:0] ackd_q, ackd_d, pend_seq, pend_seq_d, seq_diff;
  logic                 nak_pend, nak_pend_d, pend_valid, pend_valid_d, pend_nak, pend_nak_d;
  logic                 open_q, open_d;
  logic [RN_W-1:0]      replay_num, replay_num_d;
  logic [TMR_W-1:0]     timer, timer_d;

  logic [RETRY_TLP_SIZE-1:0] free_d, slot_free_q, retry_valid_q;
  logic                      rollover_d, rollover_q, active_q;
  logic                      avail, acked, dll_in, start_ok, end_ok, freed;
  logic                      enter_replay, finish, seq_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RETRY_TLP_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign avail    = (count < CNT_FULL) && (state == IDLE);
  assign seq_diff = ackd_q - seq[rd_ptr];
  // Oldest slot is covered when it lies within the half-space behind ackd
  assign acked    = (count != '0) && !seq_diff[SEQ_WIDTH-1];
  assign dll_in   = bus.ack_valid_i || bus.nak_valid_i;

  assign bus.retry_available_o = avail;
  assign bus.retry_index_o     = 8'(wr_ptr);
  assign bus.slot_free_o       = slot_free_q;
  assign bus.retry_valid_o     = retry_valid_q;
  assign bus.replay_active_o   = active_q;
  assign bus.replay_rollover_o = rollover_q;

  // Next-state and datapath
  always_comb begin
    state_d      = state;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    rp_d         = rp;
    ackd_d       = ackd_q;
    nak_pend_d   = nak_pend;
    pend_valid_d = pend_valid;
    pend_nak_d   = pend_nak;
    pend_seq_d   = pend_seq;
    replay_num_d = replay_num;
    timer_d      = timer;
    open_d       = open_q;
    free_d       = '0;
    freed        = 1'b0;
    rollover_d   = 1'b0;
    enter_replay = 1'b0;
    finish       = 1'b0;
    count_d      = count;

    if (count == '0)
      timer_d = '0;
    else if (state == IDLE && timer != TMR_LAST)
      timer_d = timer + TMR_W'(1);

    // ACK/NAK seen while busy is held (latest wins) until the block returns to IDLE
    if (state != IDLE && dll_in) begin
      pend_valid_d = 1'b1;
      pend_nak_d   = bus.nak_valid_i;
      pend_seq_d   = bus.ackd_seq_i;
    end

    case (state)
      IDLE: begin
        if (dll_in) begin
          ackd_d     = bus.ackd_seq_i;
          nak_pend_d = bus.nak_valid_i;
          state_d    = PURGE;
        end else if (count != '0 && timer == TMR_LAST) begin
          rp_d         = rd_ptr;
          enter_replay = 1'b1;
        end
      end
      PURGE: begin
        if (acked) begin
          free_d       = SLOT_ONE << rd_ptr;
          freed        = 1'b1;
          rd_ptr_d     = ptr_inc(rd_ptr);
          timer_d      = '0;
          replay_num_d = '0;
        end else if (nak_pend && count != '0) begin
          rp_d         = rd_ptr;
          enter_replay = 1'b1;
        end else begin
          nak_pend_d = 1'b0;
          finish     = 1'b1;
        end
      end
      REPLAY_REQ: begin
        if (bus.retry_ack_i[rp]) state_d = REPLAY_WAIT;
      end
      REPLAY_WAIT: begin
        if (bus.retry_complete_i[rp]) begin
          rp_d = ptr_inc(rp);
          if (ptr_inc(rp) != wr_ptr) begin
            state_d = REPLAY_REQ;
          end else begin
            timer_d    = '0;
            nak_pend_d = 1'b0;
            finish     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_replay) begin
      state_d = REPLAY_REQ;
      if (replay_num == RN_MAX) begin
        replay_num_d = '0;
        rollover_d   = 1'b1;
      end else begin
        replay_num_d = replay_num + RN_W'(1);
      end
    end

    // Leaving a busy phase: a held ACK/NAK is purged before allocation reopens
    if (finish) begin
      state_d = IDLE;
      if (dll_in) begin
        state_d      = PURGE;
        ackd_d       = bus.ackd_seq_i;
        nak_pend_d   = bus.nak_valid_i;
        pend_valid_d = 1'b0;
      end else if (pend_valid) begin
        state_d      = PURGE;
        ackd_d       = pend_seq;
        nak_pend_d   = pend_nak;
        pend_valid_d = 1'b0;
      end
    end

    // A TLP opened in IDLE may still close while PURGE is running
    start_ok = bus.tlp_start_i && avail;
    end_ok   = bus.tlp_end_i && (avail || (state == PURGE && open_q));
    seq_we   = start_ok;
    if (start_ok)
      open_d = !bus.tlp_end_i;
    else if (bus.tlp_end_i)
      open_d = 1'b0;
    if (end_ok) wr_ptr_d = ptr_inc(wr_ptr);
    count_d = count + CNT_W'(end_ok) - CNT_W'(freed);
  end

  always_ff @(posedge clk_i) begin
    if (seq_we) seq[wr_ptr] <= bus.tlp_seq_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rp            <= '0;
      count         <= '0;
      ackd_q        <= '0;
      nak_pend      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_nak      <= 1'b0;
      pend_seq      <= '0;
      open_q        <= 1'b0;
      replay_num    <= '0;
      timer         <= '0;
      slot_free_q   <= '0;
      retry_valid_q <= '0;
      active_q      <= 1'b0;
      rollover_q    <= 1'b0;
    end else begin
      state         <= state_d;
      wr_ptr        <= wr_ptr_d;
      rd_ptr        <= rd_ptr_d;
      rp            <= rp_d;
      count         <= count_d;
      ackd_q        <= ackd_d;
      nak_pend      <= nak_pend_d;
      pend_valid    <= pend_valid_d;
      pend_nak      <= pend_nak_d;
      pend_seq      <= pend_seq_d;
      open_q        <= open_d;
      replay_num    <= replay_num_d;
      timer         <= timer_d;
      slot_free_q   <= free_d;
      retry_valid_q <= (state_d == REPLAY_REQ) ? (SLOT_ONE << rp_d) : '0;
      active_q      <= (state_d == REPLAY_REQ) || (state_d == REPLAY_WAIT);
      rollover_q    <= rollover_d;
    end
  end

endmodule
